// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer: state encoding, pattern word layout
// and the helpers that clamp the step period and gate length.
package note_sequencer_pkg;

  localparam int DEFAULT_PRESCALE = 2048;
  localparam int PAT_W            = 13;
  localparam int PAT_EN_BIT       = 12;
  localparam int OSC_W            = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_REST = 2'd2
  } seq_state_t;

  // A step lasts at least two ticks so a gated step always has trig low for one tick.
  function automatic logic [15:0] eff_period(input logic [15:0] period);
    return (period < 16'd2) ? 16'd2 : period;
  endfunction

  function automatic logic [15:0] eff_gate(input logic [7:0] gate, input logic [15:0] eperiod);
    logic [15:0] gate_w;
    gate_w = {8'd0, gate};
    return (gate_w < eperiod) ? gate_w : (eperiod - 16'd1);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, pattern-write and note-output signals between the host side and the sequencer.
interface note_sequencer_if
  import note_sequencer_pkg::*;
#(
  parameter int STEPS = 8
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic              run;
  logic [SW-1:0]     last_step;
  logic [15:0]       step_period;
  logic [7:0]        gate_len;
  logic              wr_en;
  logic [SW-1:0]     wr_addr;
  logic [PAT_W-1:0]  wr_data;
  logic              trig;
  logic [OSC_W-1:0]  osc_count;
  logic [SW-1:0]     step;
  logic              step_stb;

  modport master (
    output run, last_step, step_period, gate_len, wr_en, wr_addr, wr_data,
    input  trig, osc_count, step, step_stb
  );

  modport slave (
    input  run, last_step, step_period, gate_len, wr_en, wr_addr, wr_data,
    output trig, osc_count, step, step_stb
  );

endinterface

// File: rtl/note_sequencer_tick_gen.sv
// Free-running prescaler: a down-counter that flags one tick every PRESCALE clocks.
module tick_gen
  import note_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == '0) ? CW'(PRESCALE - 1) : (cnt_q - CW'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer that plays a STEPS-deep pitch pattern as gated triggers, one step per period.
//   state   | meaning
//   IDLE    | stopped; trig low, step 0, waiting for run and a tick
//   GATE    | step playing with trig high until the gate length expires
//   REST    | trig low until the step period expires, then next step starts
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int STEPS    = 8
) (
  input  logic clk,
  input  logic rstn,
  note_sequencer_if.slave bus
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic             tick;
  logic [PAT_W-1:0] pattern_q [STEPS];
  seq_state_t       state_q;
  logic [15:0]      tcnt_q;
  logic [15:0]      tcnt_d;
  logic             trig_q;
  logic [OSC_W-1:0] osc_q;
  logic [SW-1:0]    step_q;
  logic             stb_q;

  logic [15:0]      per_eff;
  logic [15:0]      gate_eff;
  logic [SW-1:0]    start_step;
  logic [PAT_W-1:0] start_word;
  logic             do_start;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STEPS; i++) pattern_q[i] <= '0;
    end else if (bus.wr_en) begin
      pattern_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    per_eff    = eff_period(bus.step_period);
    gate_eff   = eff_gate(bus.gate_len, per_eff);
    tcnt_d     = tcnt_q + 16'd1;
    start_step = '0;
    if (state_q != ST_IDLE && step_q < bus.last_step) start_step = step_q + SW'(1);
    start_word = pattern_q[start_step];
    do_start   = tick && ((state_q == ST_IDLE) || (tcnt_d >= per_eff));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      trig_q  <= 1'b0;
      osc_q   <= '0;
      step_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (!bus.run) begin
        state_q <= ST_IDLE;
        tcnt_q  <= '0;
        trig_q  <= 1'b0;
        step_q  <= '0;
      end else if (do_start) begin
        step_q <= start_step;
        stb_q  <= 1'b1;
        tcnt_q <= '0;
        // Disabled steps keep the previous pitch so the synth is not retuned while silent.
        if (start_word[PAT_EN_BIT]) osc_q <= start_word[OSC_W-1:0];
        if (start_word[PAT_EN_BIT] && gate_eff != 16'd0) begin
          state_q <= ST_GATE;
          trig_q  <= 1'b1;
        end else begin
          state_q <= ST_REST;
          trig_q  <= 1'b0;
        end
      end else if (tick && state_q != ST_IDLE) begin
        tcnt_q <= tcnt_d;
        if (state_q == ST_GATE && tcnt_d >= gate_eff) begin
          state_q <= ST_REST;
          trig_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.trig      = trig_q;
  assign bus.osc_count = osc_q;
  assign bus.step      = step_q;
  assign bus.step_stb  = stb_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with PRESCALE=4: pattern playback, clamping table,
// run stop/restart, write-while-playing and asynchronous reset mid-gate.
module tb_note_sequencer;
  localparam int PRESCALE = 4;
  localparam int STEPS    = 8;
  localparam int BUDGET   = 2000;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  note_sequencer_if #(.STEPS(STEPS)) bus ();

  note_sequencer #(.PRESCALE(PRESCALE), .STEPS(STEPS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] period;
    logic [7:0]  gate;
    int          exp_high;
    int          exp_intv;
  } vec_t;

  typedef struct {
    int step;
    int osc;
    int high;
  } seq_t;

  vec_t vecs [5];
  seq_t seqs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic write_slot(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = 13'(data);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    while (!bus.step_stb && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!bus.step_stb) check("stb_timeout", int'(bus.step_stb), 1);
  endtask

  // Called at a negedge where step_stb is high; returns at the next step start.
  task automatic measure(output int stp, output int osc, output int high, output int intv);
    stp  = int'(bus.step);
    osc  = int'(bus.osc_count);
    high = 0;
    intv = 0;
    do begin
      if (bus.trig) high++;
      @(negedge clk);
      intv++;
    end while (!bus.step_stb && intv < BUDGET);
    if (!bus.step_stb) check("measure_timeout", int'(bus.step_stb), 1);
  endtask

  initial begin
    int n, stp, osc, high, intv;
    checks = 0;
    errors = 0;

    vecs[0] = '{16'd10, 8'd3,   12, 40};
    vecs[1] = '{16'd5,  8'd255, 16, 20};
    vecs[2] = '{16'd0,  8'd1,   4,  8};
    vecs[3] = '{16'd1,  8'd0,   0,  8};
    vecs[4] = '{16'd3,  8'd2,   8,  12};

    seqs[0] = '{0, 'h100, 12};
    seqs[1] = '{1, 'h200, 12};
    seqs[2] = '{2, 'h200, 0};
    seqs[3] = '{3, 'h400, 12};
    seqs[4] = '{0, 'h100, 12};

    rstn            = 1'b0;
    bus.run         = 1'b0;
    bus.last_step   = 3'd3;
    bus.step_period = 16'd10;
    bus.gate_len    = 8'd3;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_trig", int'(bus.trig), 0);
    check("rst_osc",  int'(bus.osc_count), 0);
    check("rst_step", int'(bus.step), 0);
    check("rst_stb",  int'(bus.step_stb), 0);
    rstn = 1'b1;
    @(negedge clk);

    write_slot(0, 'h1100);
    write_slot(1, 'h1200);
    write_slot(2, 'h0300);
    write_slot(3, 'h1400);
    repeat (3) @(negedge clk);
    check("idle_trig", int'(bus.trig), 0);
    check("idle_stb",  int'(bus.step_stb), 0);

    bus.run = 1'b1;
    wait_stb(n);
    check("start_latency_ok", int'(n >= 1 && n <= PRESCALE), 1);
    for (int i = 0; i < 5; i++) begin
      measure(stp, osc, high, intv);
      check($sformatf("seq%0d_step", i), stp, seqs[i].step);
      check($sformatf("seq%0d_osc", i),  osc, seqs[i].osc);
      check($sformatf("seq%0d_high", i), high, seqs[i].high);
      check($sformatf("seq%0d_intv", i), intv, 40);
    end

    // Now at the start of step 1 with the gate open: stop mid-gate.
    @(negedge clk);
    check("drop_pre_trig", int'(bus.trig), 1);
    bus.run = 1'b0;
    @(negedge clk);
    check("drop_trig", int'(bus.trig), 0);
    check("drop_step", int'(bus.step), 0);
    check("drop_osc",  int'(bus.osc_count), 'h200);
    repeat (10) @(negedge clk);
    check("drop_stays_idle", int'(bus.step_stb | bus.trig), 0);
    bus.run = 1'b1;
    wait_stb(n);
    check("restart_step", int'(bus.step), 0);
    check("restart_osc",  int'(bus.osc_count), 'h100);

    measure(stp, osc, high, intv);
    write_slot(1, 'h1ABC);
    check("wr_play_osc", int'(bus.osc_count), 'h200);
    measure(stp, osc, high, intv);
    check("wr_next_step", int'(bus.step), 2);
    check("wr_next_osc",  int'(bus.osc_count), 'h200);
    measure(stp, osc, high, intv);
    measure(stp, osc, high, intv);
    measure(stp, osc, high, intv);
    check("wr_replay_step", int'(bus.step), 1);
    check("wr_replay_osc",  int'(bus.osc_count), 'hABC);

    bus.run       = 1'b0;
    bus.last_step = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.step_period = vecs[i].period;
      bus.gate_len    = vecs[i].gate;
      bus.run         = 1'b1;
      wait_stb(n);
      measure(stp, osc, high, intv);
      check($sformatf("vec%0d_step", i), stp, 0);
      check($sformatf("vec%0d_osc", i),  osc, 'h100);
      check($sformatf("vec%0d_high", i), high, vecs[i].exp_high);
      check($sformatf("vec%0d_intv", i), intv, vecs[i].exp_intv);
      bus.run = 1'b0;
      @(negedge clk);
    end

    bus.last_step   = 3'd3;
    bus.step_period = 16'd10;
    bus.gate_len    = 8'd3;
    bus.run         = 1'b1;
    wait_stb(n);
    @(negedge clk);
    check("rstmid_pre_trig", int'(bus.trig), 1);
    #1 rstn = 1'b0;
    #1;
    check("rstmid_trig", int'(bus.trig), 0);
    check("rstmid_osc",  int'(bus.osc_count), 0);
    check("rstmid_step", int'(bus.step), 0);
    check("rstmid_stb",  int'(bus.step_stb), 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_stb(n);
    measure(stp, osc, high, intv);
    check("post_rst0_step", stp, 0);
    check("post_rst0_osc",  osc, 0);
    check("post_rst0_high", high, 0);
    check("post_rst0_intv", intv, 40);
    measure(stp, osc, high, intv);
    check("post_rst1_step", stp, 1);
    check("post_rst1_osc",  osc, 0);
    check("post_rst1_high", high, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 2048, system clocks per sequencer tick (10 kHz at 20.48 MHz).
REQ-002 SHALL have parameter STEPS, default 8, pattern depth; power of two.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, ports named clk and rstn.
REQ-004 clk  input  1  system clock, 20480000 Hz.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 run  input  1  level; 1 = play pattern, 0 = stop.
REQ-007 last_step  input  log2(STEPS)  index of final step before wrap to 0.
REQ-008 step_period  input  16  step duration in ticks.
REQ-009 gate_len  input  8  trig-high duration per step in ticks.
REQ-010 wr_en  input  1  pattern write strobe, one clk.
REQ-011 wr_addr  input  log2(STEPS)  pattern slot to write.
REQ-012 wr_data  input  13  bit 12 = step enable, bits 11:0 = osc_count value.
REQ-013 trig  output  1  note trigger to synth trig input.
REQ-014 osc_count  output  12  pitch word to synth osc_count input.
REQ-015 step  output  log2(STEPS)  currently playing step index.
REQ-016 step_stb  output  1  one-clk pulse at each step start.

Function
REQ-017 SHALL hold pattern in STEPS x 13-bit register array; write takes effect clk after wr_en; wr_en accepted in any state.
REQ-018 SHALL generate a one-clk tick enable every PRESCALE clks from a free-running prescaler; prescaler runs regardless of run.
REQ-019 SHALL implement states IDLE, GATE, REST.
REQ-020 IDLE: trig=0, step=0, step tick counter cleared; run=1 -> step start of step 0 on next clk.
REQ-021 Step start: SHALL latch pattern[step] into osc_count only if enable bit set (else osc_count holds), pulse step_stb, clear tick counter, enter GATE if enable=1 and effective gate > 0, else REST.
REQ-022 GATE: trig=1; after effective gate ticks -> REST, trig=0 same clk.
REQ-023 REST: trig=0; when tick counter reaches effective period -> next step start.
REQ-024 Effective period SHALL be max(step_period, 2); effective gate SHALL be min(gate_len, effective period - 1), guaranteeing >=1 tick trig low between steps.
REQ-025 Next step SHALL be 0 if step >= last_step, else step+1; last_step change mid-step applies at next advance.
REQ-026 Step start SHALL be aligned to first tick after run rises (latency <= PRESCALE clks); subsequent starts exactly effective period ticks apart.
REQ-027 run=0 in any state SHALL force IDLE next clk: trig=0 and step=0 that clk; osc_count holds last value.
REQ-028 Write to the playing slot SHALL NOT alter osc_count until that slot's next step start.
REQ-029 step_period/gate_len changes SHALL be sampled continuously; comparisons use current value (counter >= value terminates).

Reset
REQ-030 On rstn=0: pattern all zero, prescaler 0, state IDLE, trig=0, osc_count=0, step=0, step_stb=0.
REQ-031 Reset assertion mid-gate SHALL drop trig asynchronously; release resumes in IDLE.

Structure
REQ-032 Shared package SHALL hold state enum, pattern word width (13) and field positions, default PRESCALE.
REQ-033 Prescaler SHALL be sub-module tick_gen (params PRESCALE; out tick).
REQ-034 Outputs SHALL be registered; no combinational path from inputs to trig/osc_count.

Verification
REQ-035 PRESCALE=4; write slots 0..3 = 0x1100,0x1200,0x0300,0x1400; last_step=3, period=10, gate=3, run=1 -> osc_count 0x100,0x200,0x200(held, no trig),0x400, then wraps to 0x100; trig high 12 clks per enabled step.
REQ-036 gate_len=255, period=5 -> trig high 4 ticks, low 1 tick each step.
REQ-037 period=0 -> treated as 2; gate=1 -> step_stb every 8 clks.
REQ-038 run dropped mid-GATE -> trig=0 and step=0 next clk; run re-raised -> restarts at step 0.
REQ-039 Write slot 1 while step 1 playing -> osc_count unchanged until step 1 replays.
REQ-040 rstn pulsed mid-GATE -> trig falls asynchronously; all outputs and pattern zero.
